// File: rtl/rsa_pkg.sv
// Shared constants and FSM state type for the RSA decryption stage.
package rsa_pkg;

    // Operand width for ciphertext, exponent, modulus and plaintext.
    localparam int unsigned RSA_W = 24;

    // One interleaved multiply takes one cycle per multiplier bit.
    localparam int unsigned MUL_STEPS = RSA_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: res = a*b mod n in W cycles.
// The step for the go cycle is computed combinationally from a zero
// accumulator, so rdy/res appear in the W-th cycle counting the go cycle.
module mod_mul
    import rsa_pkg::*;
#(
    parameter int unsigned W = MUL_STEPS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] res,
    output logic         rdy
);

    localparam int unsigned IW = $clog2(W);

    // Two spare bits hold 2*acc and acc+a before reduction.
    logic [W+1:0]  acc_q;
    logic [W+1:0]  acc_cur;
    logic [W+1:0]  acc_dbl;
    logic [W+1:0]  acc_nxt;
    logic [W+1:0]  n_ext;
    logic [W+1:0]  a_ext;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_cur;
    logic          active_q;

    // One double-and-add step, scanning b from its MSB down.
    always_comb begin
        n_ext   = {2'b00, n};
        a_ext   = {2'b00, a};
        acc_cur = go ? '0 : acc_q;
        idx_cur = go ? IW'(W - 1) : idx_q;
        acc_dbl = acc_cur << 1;
        if (acc_dbl >= n_ext) begin
            acc_dbl = acc_dbl - n_ext;
        end
        acc_nxt = acc_dbl;
        if (b[idx_cur]) begin
            acc_nxt = acc_dbl + a_ext;
            if (acc_nxt >= n_ext) begin
                acc_nxt = acc_nxt - n_ext;
            end
        end
        rdy = (go || active_q) && (idx_cur == '0);
        res = acc_nxt[W-1:0];
    end

    // Accumulator and bit index advance while a product is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (go || active_q) begin
            acc_q    <= acc_nxt;
            idx_q    <= idx_cur - IW'(1);
            active_q <= (idx_cur != '0);
        end
    end

endmodule

// File: rtl/rsa_decrypt.sv
// Constant-time square-and-multiply decryption: m = c^d mod n.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int unsigned W = RSA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [W-1:0] d,
    input  logic [W-1:0] n,
    input  logic [W-1:0] c,
    input  logic         start,
    output logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned KW = $clog2(W);

    state_t        state_q;
    state_t        state_d;
    logic          first_q;
    logic          first_d;
    logic [W-1:0]  base_q;
    logic [W-1:0]  d_q;
    logic [W-1:0]  n_q;
    logic [W-1:0]  r_q;
    logic [W-1:0]  m_q;
    logic [KW-1:0] k_q;
    logic          accept;
    logic          mm_go;
    logic          mm_rdy;
    logic [W-1:0]  mm_b;
    logic [W-1:0]  mm_res;

    assign accept = (state_q == IDLE) && start && key_valid;
    assign mm_b   = (state_q == SQR) ? r_q : base_q;
    assign m      = m_q;

    mod_mul #(
        .W (W)
    ) u_mod_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (mm_go),
        .a     (r_q),
        .b     (mm_b),
        .n     (n_q),
        .res   (mm_res),
        .rdy   (mm_rdy)
    );

    // State register; first_q marks the opening cycle of each SQR/MUL phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        mm_go   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if ((n_q < W'(2)) || (base_q >= n_q)) begin
                    state_d = FAIL;
                end else begin
                    state_d = SQR;
                    first_d = 1'b1;
                end
            end
            SQR: begin
                busy  = 1'b1;
                mm_go = first_q;
                if (mm_rdy) begin
                    state_d = MUL;
                    first_d = 1'b1;
                end
            end
            MUL: begin
                busy  = 1'b1;
                mm_go = first_q;
                if (mm_rdy) begin
                    if (k_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SQR;
                        first_d = 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            FAIL: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, running result R, exponent bit index and plaintext.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q <= '0;
            d_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            k_q    <= '0;
            m_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        base_q <= c;
                        d_q    <= d;
                        n_q    <= n;
                    end
                end
                LOAD: begin
                    r_q <= W'(1);
                    k_q <= KW'(W - 1);
                end
                SQR: begin
                    if (mm_rdy) begin
                        r_q <= mm_res;
                    end
                end
                MUL: begin
                    if (mm_rdy) begin
                        // Product is always computed; only the commit depends on d.
                        if (d_q[k_q]) begin
                            r_q <= mm_res;
                        end
                        if (k_q == '0) begin
                            m_q <= d_q[0] ? mm_res : r_q;
                        end else begin
                            k_q <= k_q - KW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt against a plain-arithmetic modexp model.
module tb_rsa_decrypt;

    localparam int W = 24;
    localparam int LAT_OK = 2 + 2 * W * W;
    localparam int LAT_ERR = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [W-1:0] d;
    logic [W-1:0] n;
    logic [W-1:0] c;
    logic         start;
    logic [W-1:0] m;
    logic         busy;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    rsa_decrypt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .d         (d),
        .n         (n),
        .c         (c),
        .start     (start),
        .m         (m),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int total = 0;
    int bad = 0;
    logic [W-1:0] model_m;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [W-1:0] n;
        bit           exp_err;
        logic [W-1:0] exp_m;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Left-to-right binary exponentiation with 64-bit integer arithmetic.
    function automatic logic [W-1:0] ref_exp(logic [W-1:0] cc, logic [W-1:0] dd,
                                             logic [W-1:0] nn);
        longint unsigned r = 1;
        longint unsigned b = 64'(cc);
        longint unsigned mm = 64'(nn);
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (dd[i]) r = (r * b) % mm;
        end
        return r[W-1:0];
    endfunction

    // mode 0: plain; mode 1: extra start mid-run; mode 2: reset at T+500.
    task automatic run_op(input logic [W-1:0] ci, input logic [W-1:0] di,
                          input logic [W-1:0] ni, input int mode, output int lat,
                          output logic [W-1:0] mo, output bit gd, output bit ge,
                          output bit busy_ok, output bit rst_ok);
        gd = 0; ge = 0; busy_ok = 1; rst_ok = 0; lat = 0; mo = '0;
        @(negedge clk);
        c = ci; d = di; n = ni; key_valid = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int cur = 1; cur <= 1300; cur++) begin
            @(negedge clk);
            if (mode == 2 && cur == 501) begin
                rst_ok = (m == '0) && !busy && !done && !err;
                rst_n = 1'b1;
                return;
            end
            if (done || err) begin
                gd = done; ge = err; lat = cur; mo = m;
                if (busy) busy_ok = 0;
                return;
            end
            if (!busy) busy_ok = 0;
            start = 1'b0;
            c = W'($urandom); d = W'($urandom); n = W'($urandom);
            if (mode == 1 && cur == 300) start = 1'b1;
            if (mode == 2 && cur == 500) rst_n = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0] mo;
        bit gd, ge, bok, rok, stray;
        logic [W-1:0] rn;

        rst_n = 1'b0; start = 1'b0; key_valid = 1'b0; c = '0; d = '0; n = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m", 32'(m), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        model_m = '0;

        vecs[0] = '{24'd2790, 24'd2753, 24'd3233, 1'b0, 24'd65};
        vecs[1] = '{24'd0, 24'd2753, 24'd3233, 1'b0, 24'd0};
        vecs[2] = '{24'd1, 24'd2753, 24'd3233, 1'b0, 24'd1};
        vecs[3] = '{24'd3233, 24'd2753, 24'd3233, 1'b1, 24'd0};
        vecs[4] = '{24'd2790, 24'd0, 24'd3233, 1'b0, 24'd1};
        vecs[5] = '{24'd2790, 24'hFFFFFF, 24'd3233, 1'b0, 24'd0};
        vecs[5].exp_m = ref_exp(vecs[5].c, vecs[5].d, vecs[5].n);
        vecs[6] = '{24'd2790, 24'd1, 24'd3233, 1'b0, 24'd2790};
        vecs[7] = '{24'd5, 24'd7, 24'd1, 1'b1, 24'd0};
        vecs[8] = '{24'd0, 24'd7, 24'd0, 1'b1, 24'd0};
        vecs[9] = '{24'd3232, 24'd3, 24'd3233, 1'b0, 24'd3232};
        for (int i = 10; i < 14; i++) begin
            rn = W'($urandom_range(2, 24'hFFFFFF));
            vecs[i].n = rn;
            vecs[i].c = W'($urandom % 32'(rn));
            vecs[i].d = W'($urandom);
            vecs[i].exp_err = 1'b0;
            vecs[i].exp_m = ref_exp(vecs[i].c, vecs[i].d, vecs[i].n);
        end
        rn = W'($urandom_range(2, 24'hFFFFF0));
        vecs[14] = '{W'(32'(rn) + $urandom_range(0, 15)), W'($urandom), rn, 1'b1, 24'd0};
        vecs[15] = '{24'hFFFFFE, W'($urandom), 24'hFFFFFF, 1'b0, 24'd0};
        vecs[15].exp_m = ref_exp(vecs[15].c, vecs[15].d, vecs[15].n);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].c, vecs[i].d, vecs[i].n, 0, lat, mo, gd, ge, bok, rok);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_err", i), 32'(ge), 32'h1);
                chk($sformatf("v%0d_lat", i), 32'(lat), 32'(LAT_ERR));
                chk($sformatf("v%0d_m_kept", i), 32'(mo), 32'(model_m));
                stray = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (done || err || busy) stray = 1;
                end
                chk($sformatf("v%0d_quiet", i), 32'(stray), 32'h0);
            end else begin
                chk($sformatf("v%0d_done", i), 32'(gd), 32'h1);
                chk($sformatf("v%0d_lat", i), 32'(lat), 32'(LAT_OK));
                chk($sformatf("v%0d_m", i), 32'(mo), 32'(vecs[i].exp_m));
                chk($sformatf("v%0d_busy", i), 32'(bok), 32'h1);
                model_m = vecs[i].exp_m;
            end
        end

        // start with key_valid low must not launch anything.
        @(negedge clk);
        c = 24'd2790; d = 24'd2753; n = 24'd3233; key_valid = 1'b0; start = 1'b1;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || err) stray = 1;
        end
        chk("no_key_ignored", 32'(stray), 32'h0);
        chk("no_key_m_kept", 32'(m), 32'(model_m));
        start = 1'b0; key_valid = 1'b1;

        // Second start while busy is ignored.
        run_op(24'd2790, 24'd2753, 24'd3233, 1, lat, mo, gd, ge, bok, rok);
        chk("midstart_done", 32'(gd), 32'h1);
        chk("midstart_lat", 32'(lat), 32'(LAT_OK));
        chk("midstart_m", 32'(mo), 32'd65);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || err) stray = 1;
        end
        chk("midstart_no_relaunch", 32'(stray), 32'h0);

        // Reset mid-run, then a fresh decryption.
        run_op(24'd2790, 24'd2753, 24'd3233, 2, lat, mo, gd, ge, bok, rok);
        chk("midreset_outputs_zero", 32'(rok), 32'h1);
        chk("midreset_no_done", 32'(gd), 32'h0);
        model_m = '0;
        run_op(24'd2790, 24'd2753, 24'd3233, 0, lat, mo, gd, ge, bok, rok);
        chk("postreset_done", 32'(gd), 32'h1);
        chk("postreset_lat", 32'(lat), 32'(LAT_OK));
        chk("postreset_m", 32'(mo), 32'd65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
# rsa_decrypt

Modular-exponentiation decryption stage that sits directly downstream of the key generator. It consumes the private exponent `d`, modulus `n` and the `complete` flag produced by key generation, accepts a 24-bit ciphertext word, and returns the plaintext `m = c^d mod n`. The datapath is a square-and-multiply engine built on a bit-serial interleaved modular multiplier. Latency is constant and independent of the key value.

## Interface
- `W`, 24: operand width for c, d, n and m.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `key_valid`  in  1  key generation complete; ties to the key generator's `complete` output.
- `d`  in  W  private exponent.
- `n`  in  W  modulus.
- `c`  in  W  ciphertext.
- `start`  in  1  request decryption; sampled only in IDLE.
- `m`  out  W  plaintext result; held until the next accepted start.
- `busy`  out  1  high from the cycle after accept until `done` or `err`.
- `done`  out  1  one-cycle pulse; `m` is valid in that cycle.
- `err`  out  1  one-cycle pulse; operands were rejected.

## Operation
- **Reset values:** all outputs are 0 (`m`, `busy`, `done`, `err`); state is IDLE.
- **Accept:** in IDLE, when `start && key_valid` is high, latch `c`, `d` and `n` into internal registers. Later input changes are ignored.
- **`start` outside IDLE, or with `key_valid` low:** ignored, with no effect.
- **States:** IDLE → LOAD → SQR → MUL → (SQR | DONE) → IDLE; also LOAD → FAIL → IDLE.
- **LOAD (1 cycle):**
  - If `n < 2` or `c >= n`, go to FAIL. FAIL pulses `err`, leaves `m` unchanged and returns to IDLE.
  - Otherwise set R = 1, base = c, bit index k = W-1.
- **SQR (W cycles):** R = R·R mod n.
- **MUL (W cycles):** T = R·base mod n, computed every time for constant time. Commit R = T only if `d[k]` = 1; otherwise R is unchanged.
  - If k = 0, go to DONE.
  - Otherwise decrement k and go to SQR.
- **DONE (1 cycle):** `m` = R, `done` = 1, `busy` = 0, then IDLE.
- **Modular multiply (a·b mod n, with a, b < n):** acc = 0, then for i = W-1 down to 0, one step per cycle:
  - acc = 2·acc; if acc ≥ n, acc −= n.
  - If b[i] = 1: acc += a; if acc ≥ n, acc −= n.
  - Intermediates are W+2 bits wide. No 48-bit product is ever formed.
- **`d` = 0:** m = 1 (or 0 when the result is reduced mod n = 1, but n < 2 is already rejected).
- **Reset mid-operation:** aborts immediately; outputs return to reset values and no `done` is emitted.

## Timing
- Accept cycle T: `busy` rises at T+1 (LOAD).
- FAIL path: `err` pulses at T+2; `busy` falls at T+2.
- Success path: SQR/MUL run from T+2 through T+1+2·W·W = T+1153. `done` pulses at T+1154 for W = 24 (general case: T+2+2·W²).
- A new `start` is accepted earliest in the cycle after `done` or `err`.
- `m` updates only in the DONE cycle.

## Structure
- Package `rsa_pkg`:
  - `RSA_W` = 24.
  - State enum: IDLE, LOAD, SQR, MUL, DONE, FAIL.
  - Multiplier step-count constant.
- Sub-module `mod_mul`:
  - Ports: `clk`, `rst_n`, `go`, `a`, `b`, `n`, `res`, `rdy`.
  - Bit-serial interleaved multiplier, W cycles per product.
  - Instantiated once and shared between SQR and MUL.
- Top level holds the FSM, the bit index k, and the R, base, d and n registers.

## Test plan
- n=3233, d=2753, c=2790, start → `done` at T+1154 with m=65, and `busy` high throughout.
- n=3233, d=2753, c=0 → m=0; c=1 → m=1.
- c=3233 with n=3233 (c ≥ n) → `err` pulse at T+2, no `done`, and `m` keeps its prior value.
- `start` pulsed mid-operation, and `start` with `key_valid` low → ignored; the first result is unaffected.
- `rst_n` low at cycle T+500 → all outputs 0 the next cycle; a fresh start afterwards yields the correct m=65.
- d=0, n=3233, c=2790 → m=1. d=0xFFFFFF and d=1 → latency is identical (1154 cycles).
